// File: rtl/fpnew_pkg.sv
// Shared FPU types: formats, rounding modes, status flags and the sdotp chain sequencer states.
package fpnew_pkg;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        ROD = 3'b101,
        DYN = 3'b111
    } roundmode_e;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    // Shared with the planned pipelined chain variant.
    typedef enum logic [2:0] {
        SDC_IDLE  = 3'd0,
        SDC_ISSUE = 3'd1,
        SDC_WAIT  = 3'd2,
        SDC_DONE  = 3'd3,
        SDC_DRAIN = 3'd4
    } sdotp_chain_state_e;

endpackage

// File: rtl/fpnew_sdotp_chain_seq.sv
// Reduces a packed-vector dot product to NumPairs dependent two-element sdotp steps
// on one external unit, chaining each step result into the next addend.
module fpnew_sdotp_chain_seq
    import fpnew_pkg::*;
#(
    parameter int unsigned SrcWidth = 16,
    parameter int unsigned DstWidth = 32,
    parameter int unsigned NumPairs = 4,
    parameter type         TagType  = logic,
    localparam int unsigned VecWidth = 2 * NumPairs * SrcWidth
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic [VecWidth-1:0] op_a_i,
    input  logic [VecWidth-1:0] op_b_i,
    input  logic [DstWidth-1:0] acc_i,
    input  roundmode_e          rnd_mode_i,
    input  fp_format_e          src_fmt_i,
    input  fp_format_e          dst_fmt_i,
    input  TagType              tag_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    output logic [SrcWidth-1:0] unit_a_o,
    output logic [SrcWidth-1:0] unit_b_o,
    output logic [SrcWidth-1:0] unit_c_o,
    output logic [SrcWidth-1:0] unit_d_o,
    output logic [DstWidth-1:0] unit_acc_o,
    output roundmode_e          unit_rnd_mode_o,
    output fp_format_e          unit_src_fmt_o,
    output fp_format_e          unit_dst_fmt_o,
    output logic                unit_valid_o,
    input  logic                unit_ready_i,
    input  logic [DstWidth-1:0] unit_result_i,
    input  status_t             unit_status_i,
    input  logic                unit_valid_i,
    output logic                unit_ready_o,
    output logic [DstWidth-1:0] result_o,
    output status_t             status_o,
    output TagType              tag_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                busy_o
);

    localparam int unsigned KW = (NumPairs > 1) ? $clog2(NumPairs) : 1;
    localparam logic [KW-1:0] KLast = KW'(NumPairs - 1);

    sdotp_chain_state_e state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [VecWidth-1:0] a_q, a_d;
    logic [VecWidth-1:0] b_q, b_d;
    logic [DstWidth-1:0] acc_q, acc_d;
    logic [DstWidth-1:0] res_q, res_d;
    status_t             status_q, status_d;
    roundmode_e          rnd_q, rnd_d;
    fp_format_e          src_fmt_q, src_fmt_d;
    fp_format_e          dst_fmt_q, dst_fmt_d;
    TagType              tag_q, tag_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= SDC_IDLE;
            k_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            res_q     <= '0;
            status_q  <= '0;
            rnd_q     <= RNE;
            src_fmt_q <= FP32;
            dst_fmt_q <= FP32;
            tag_q     <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            res_q     <= res_d;
            status_q  <= status_d;
            rnd_q     <= rnd_d;
            src_fmt_q <= src_fmt_d;
            dst_fmt_q <= dst_fmt_d;
            tag_q     <= tag_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        res_d     = res_q;
        status_d  = status_q;
        rnd_d     = rnd_q;
        src_fmt_d = src_fmt_q;
        dst_fmt_d = dst_fmt_q;
        tag_d     = tag_q;

        unique case (state_q)
            SDC_IDLE: begin
                if (in_valid_i) begin
                    a_d       = op_a_i;
                    b_d       = op_b_i;
                    acc_d     = acc_i;
                    rnd_d     = rnd_mode_i;
                    src_fmt_d = src_fmt_i;
                    dst_fmt_d = dst_fmt_i;
                    tag_d     = tag_i;
                    k_d       = '0;
                    status_d  = '0;
                    state_d   = SDC_ISSUE;
                end
            end
            SDC_ISSUE: begin
                // A step handed over in the flush cycle still owes a response.
                if (flush_i) begin
                    state_d = unit_ready_i ? SDC_DRAIN : SDC_IDLE;
                end else if (unit_ready_i) begin
                    state_d = SDC_WAIT;
                end
            end
            SDC_WAIT: begin
                // A response arriving with the flush is consumed here, so nothing is left to drain.
                if (flush_i) begin
                    state_d = unit_valid_i ? SDC_IDLE : SDC_DRAIN;
                end else if (unit_valid_i) begin
                    res_d    = unit_result_i;
                    status_d = status_t'(status_q | unit_status_i);
                    if (k_q == KLast) begin
                        state_d = SDC_DONE;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = SDC_ISSUE;
                    end
                end
            end
            SDC_DONE: begin
                if (flush_i || out_ready_i) begin
                    state_d = SDC_IDLE;
                end
            end
            SDC_DRAIN: begin
                if (unit_valid_i) begin
                    state_d = SDC_IDLE;
                end
            end
            default: state_d = SDC_IDLE;
        endcase
    end

    always_comb begin
        unit_a_o = '0;
        unit_b_o = '0;
        unit_c_o = '0;
        unit_d_o = '0;
        for (int unsigned p = 0; p < NumPairs; p++) begin
            if (k_q == KW'(p)) begin
                unit_a_o = a_q[(2*p)*SrcWidth +: SrcWidth];
                unit_b_o = b_q[(2*p)*SrcWidth +: SrcWidth];
                unit_c_o = a_q[(2*p+1)*SrcWidth +: SrcWidth];
                unit_d_o = b_q[(2*p+1)*SrcWidth +: SrcWidth];
            end
        end
    end

    assign unit_acc_o      = (k_q == '0) ? acc_q : res_q;
    assign unit_rnd_mode_o = rnd_q;
    assign unit_src_fmt_o  = src_fmt_q;
    assign unit_dst_fmt_o  = dst_fmt_q;

    assign in_ready_o   = (state_q == SDC_IDLE);
    assign unit_valid_o = (state_q == SDC_ISSUE);
    assign unit_ready_o = (state_q == SDC_WAIT) || (state_q == SDC_DRAIN);
    assign out_valid_o  = (state_q == SDC_DONE);
    assign busy_o       = (state_q != SDC_IDLE);

    assign result_o = res_q;
    assign status_o = status_q;
    assign tag_o    = tag_q;

endmodule
